// File: rtl/s86_timer_array_if.sv
// s86_timer_array_if: S86 port-I/O bus bundle (address, data, strobes).
// The master drives address/data/strobes; the slave returns read data.
interface s86_timer_array_if #(
  parameter int ADR_W = 4
);
  logic [ADR_W-1:0] wb_adr_i;
  logic [15:0]      wb_dat_i;
  logic [15:0]      wb_dat_o;
  logic             CS_N;
  logic             IOR_N;
  logic             IOW_N;

  modport master (
    output wb_adr_i, wb_dat_i, CS_N, IOR_N, IOW_N,
    input  wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, CS_N, IOR_N, IOW_N,
    output wb_dat_o
  );
endinterface

// File: rtl/s86_timer_array.sv
// s86_timer_array: NCH-channel programmable interval timer on the S86 bus.
// Define S86_TIMER_CASCADE_EN to let channel i>0 count on channel i-1 TCs.
module s86_timer_array #(
  parameter int NCH   = 4,
  parameter int CW    = 16,
  parameter int ADR_W = 2 + $clog2(NCH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  s86_timer_array_if.slave bus,
  input  logic             tick_i,
  input  logic [NCH-1:0]   gate_i,
  output logic [NCH-1:0]   out_o,
  output logic             irq_o
);
  // one spare bit so a reload of 0 can hold the full 2^CW count
  typedef logic [CW:0] cnt_t;

  function automatic cnt_t f_ld(input logic [CW-1:0] v);
    return (v == '0) ? (cnt_t'(1) << CW) : {1'b0, v};
  endfunction

  logic [1:0]     r_mode [NCH];
  logic [CW-1:0]  r_rld  [NCH];
  cnt_t           r_cnt  [NCH];
  logic [NCH-1:0] r_en;
  logic [NCH-1:0] r_ie;
  logic [NCH-1:0] r_out;
  logic [NCH-1:0] r_tc;
  logic           r_wr_prev;
  logic           r_irq;

  logic             w_stb;
  logic             w_wr;
  logic             w_rd;
  logic [1:0]       w_reg;
  logic [ADR_W-1:0] w_chn;
  logic [NCH-1:0]   w_sel;
  logic [NCH-1:0]   w_cas;
  logic [NCH-1:0]   w_ld;
  logic [NCH-1:0]   w_ldo;
  logic [NCH-1:0]   w_src;
  logic [NCH-1:0]   w_ev;
  logic [NCH-1:0]   w_tcp;
  cnt_t             w_ldv [NCH];
  logic [15:0]      w_rdat;
  logic             w_unused;

  assign w_stb    = ~bus.CS_N & ~bus.IOW_N;
  assign w_wr     = w_stb & ~r_wr_prev;
  assign w_rd     = ~bus.CS_N & ~bus.IOR_N;
  assign w_reg    = bus.wb_adr_i[1:0];
  assign w_chn    = bus.wb_adr_i >> 2;
  assign w_unused = &{1'b0, bus.wb_dat_i};

`ifdef S86_TIMER_CASCADE_EN
  logic [NCH-1:0] r_cas;
  assign w_cas = r_cas;
`else
  assign w_cas = '0;
`endif

  // a load (CTRL/RELOAD write) swallows any tick in the same cycle
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_sel[i] = (w_chn == ADR_W'(i));
      w_ld[i]  = w_wr & w_sel[i] & ~w_reg[1];
      w_ldv[i] = f_ld(w_reg[0] ? bus.wb_dat_i[CW-1:0] : r_rld[i]);
      w_ldo[i] = w_reg[0] ? r_mode[i][1] : bus.wb_dat_i[1];
      w_src[i] = tick_i;
`ifdef S86_TIMER_CASCADE_EN
      if (i > 0 && w_cas[i])
        w_src[i] = w_tcp[(i > 0) ? i - 1 : 0];
`endif
      w_ev[i]  = w_src[i] & r_en[i] & gate_i[i] & ~w_ld[i];
      w_tcp[i] = w_ev[i] & (r_cnt[i] == cnt_t'(1));
    end
  end

  always_comb begin
    w_rdat = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_rd && w_sel[i]) begin
        unique case (w_reg)
          2'd0: w_rdat = {11'd0, w_cas[i], r_ie[i],
                          r_en[i], r_mode[i]};
          2'd1: w_rdat = 16'(r_rld[i]);
          2'd2: w_rdat = 16'(r_cnt[i][CW-1:0]);
          default: w_rdat = {14'd0, r_out[i], r_tc[i]};
        endcase
      end
    end
  end

  assign bus.wb_dat_o = w_rdat;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wr_prev <= 1'b0;
      r_irq     <= 1'b0;
      r_en      <= '0;
      r_ie      <= '0;
      r_out     <= '0;
      r_tc      <= '0;
`ifdef S86_TIMER_CASCADE_EN
      r_cas     <= '0;
`endif
      for (int i = 0; i < NCH; i++) begin
        r_mode[i] <= '0;
        r_rld[i]  <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      r_wr_prev <= w_stb;
      r_irq     <= |(r_tc & r_ie);
      for (int i = 0; i < NCH; i++) begin
        if (w_wr && w_sel[i] && w_reg == 2'd0) begin
          r_mode[i] <= bus.wb_dat_i[1:0];
          r_en[i]   <= bus.wb_dat_i[2];
          r_ie[i]   <= bus.wb_dat_i[3];
`ifdef S86_TIMER_CASCADE_EN
          r_cas[i]  <= bus.wb_dat_i[4];
`endif
        end
        if (w_wr && w_sel[i] && w_reg == 2'd1)
          r_rld[i] <= bus.wb_dat_i[CW-1:0];
        if (w_ld[i]) begin
          r_cnt[i] <= w_ldv[i];
          r_out[i] <= w_ldo[i];
        end else if (r_en[i]) begin
          if (!gate_i[i]) begin
            if (r_mode[i][1])
              r_out[i] <= 1'b1;
          end else if (!r_mode[i][1]) begin
            if (w_ev[i] && r_cnt[i] != '0)
              r_cnt[i] <= r_cnt[i] - cnt_t'(1);
            if (w_tcp[i])
              r_out[i] <= 1'b1;
          end else if (w_tcp[i]) begin
            r_cnt[i] <= f_ld(r_rld[i]);
            r_out[i] <= r_mode[i][0] & ~r_out[i];
          end else begin
            if (w_ev[i])
              r_cnt[i] <= r_cnt[i] - cnt_t'(1);
            if (!r_mode[i][0])
              r_out[i] <= 1'b1;
          end
        end
        if (w_tcp[i])
          r_tc[i] <= 1'b1;
        else if (w_wr && w_sel[i] && w_reg == 2'd3
                 && bus.wb_dat_i[0])
          r_tc[i] <= 1'b0;
      end
    end
  end

  assign out_o = r_out;
  assign irq_o = r_irq;
endmodule

// File: tb/tb_s86_timer_array.sv
// tb_s86_timer_array: directed + random stimulus for s86_timer_array,
// checked every cycle against a tick-level behavioural model.
module tb_s86_timer_array;
  localparam int NCH  = 3;
  localparam int CW   = 8;
  localparam int AW   = 2 + $clog2(NCH);
  localparam int FULL = 1 << CW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tick = 1'b0;
  logic [NCH-1:0] gate = '0;
  logic [NCH-1:0] out_o;
  logic           irq_o;

  s86_timer_array_if #(.ADR_W(AW)) bus ();

  s86_timer_array #(.NCH(NCH), .CW(CW), .ADR_W(AW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .tick_i   (tick),
    .gate_i   (gate),
    .out_o    (out_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 0;

  int m_mode [NCH];
  int m_rld  [NCH];
  int m_cnt  [NCH];
  bit m_en   [NCH];
  bit m_ie   [NCH];
  bit m_cas  [NCH];
  bit m_out  [NCH];
  bit m_tc   [NCH];
  bit m_prev;
  bit m_irq;
  logic [NCH-1:0] eo;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // one clock edge of the timer, stated in terms of ticks and counts
  task automatic model_edge();
    bit stb, wr, ld, ev, src, irq_n;
    bit tcp [NCH];
    int ch, rg, dat;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0; m_rld[i] = 0; m_cnt[i] = 0;
        m_en[i] = 0; m_ie[i] = 0; m_cas[i] = 0;
        m_out[i] = 0; m_tc[i] = 0;
      end
      m_prev = 0;
      m_irq  = 0;
    end else begin
      ch  = int'(bus.wb_adr_i) >> 2;
      rg  = int'(bus.wb_adr_i) & 3;
      dat = int'(bus.wb_dat_i);
      stb = !bus.CS_N && !bus.IOW_N;
      wr  = stb && !m_prev;
      m_prev = stb;
      irq_n = 0;
      for (int i = 0; i < NCH; i++) irq_n |= m_tc[i] & m_ie[i];
      for (int i = 0; i < NCH; i++) begin
        ld  = wr && ch == i && rg < 2;
        src = tick;
`ifdef S86_TIMER_CASCADE_EN
        if (i > 0 && m_cas[i]) src = tcp[(i > 0) ? i - 1 : 0];
`endif
        ev = src && m_en[i] && gate[i] && !ld;
        tcp[i] = ev && m_cnt[i] == 1;
        if (ld) begin
          if (rg == 0) begin
            m_mode[i] = dat & 3;
            m_en[i]   = dat[2];
            m_ie[i]   = dat[3];
`ifdef S86_TIMER_CASCADE_EN
            m_cas[i]  = dat[4];
`endif
          end else begin
            m_rld[i] = dat % FULL;
          end
          m_cnt[i] = (m_rld[i] == 0) ? FULL : m_rld[i];
          m_out[i] = m_mode[i] >= 2;
        end else if (m_en[i]) begin
          if (!gate[i]) begin
            if (m_mode[i] >= 2) m_out[i] = 1;
          end else if (m_mode[i] < 2) begin
            if (ev && m_cnt[i] > 0) begin
              m_cnt[i]--;
              if (m_cnt[i] == 0) m_out[i] = 1;
            end
          end else if (ev && m_cnt[i] == 1) begin
            m_cnt[i] = (m_rld[i] == 0) ? FULL : m_rld[i];
            m_out[i] = (m_mode[i] == 3) ? !m_out[i] : 1'b0;
          end else begin
            if (ev) m_cnt[i]--;
            if (m_mode[i] == 2) m_out[i] = 1;
          end
        end
        if (tcp[i]) m_tc[i] = 1;
        else if (wr && ch == i && rg == 3 && dat[0]) m_tc[i] = 0;
      end
      m_irq = irq_n;
    end
  endtask

  function automatic logic [15:0] exp_rd();
    int ch, rg;
    ch = int'(bus.wb_adr_i) >> 2;
    rg = int'(bus.wb_adr_i) & 3;
    if (bus.CS_N || bus.IOR_N || ch >= NCH) return 16'h0;
    case (rg)
      0: return 16'(m_mode[ch] + 4 * m_en[ch] + 8 * m_ie[ch]
                    + 16 * m_cas[ch]);
      1: return 16'(m_rld[ch]);
      2: return 16'(m_cnt[ch] % FULL);
      default: return 16'(m_tc[ch] + 2 * m_out[ch]);
    endcase
  endfunction

  always @(posedge clk) model_edge();

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      for (int i = 0; i < NCH; i++) eo[i] = m_out[i];
      chk("out_o", 32'(out_o), 32'(eo));
      chk("irq_o", 32'(irq_o), 32'(m_irq));
      chk("wb_dat_o", 32'(bus.wb_dat_o), 32'(exp_rd()));
    end
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    bus.wb_adr_i = AW'(a);
    bus.wb_dat_i = 16'(d);
    bus.CS_N = 0;
    bus.IOW_N = 0;
    @(negedge clk);
    bus.CS_N = 1;
    bus.IOW_N = 1;
  endtask

  task automatic rd(input string nm, input int a, input int e);
    @(negedge clk);
    bus.wb_adr_i = AW'(a);
    bus.CS_N = 0;
    bus.IOR_N = 0;
    #1;
    chk(nm, 32'(bus.wb_dat_o), 32'(e));
    @(negedge clk);
    bus.CS_N = 1;
    bus.IOR_N = 1;
  endtask

  task automatic period(input int ch, input int budget,
                        output int per);
    logic prev;
    int   t1;
    prev = out_o[ch];
    t1   = -1;
    per  = -1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (out_o[ch] !== prev) begin
        prev = out_o[ch];
        if (t1 < 0) t1 = c;
        else begin
          per = c - t1;
          break;
        end
      end
    end
  endtask

  int per, lows, first;

  initial begin
    bus.CS_N = 1; bus.IOR_N = 1; bus.IOW_N = 1;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    rst = 0;
    for (int a = 0; a < 16; a++) rd("reset_rd", a, 0);
    chk("reset_out", 32'(out_o), 0);
    chk("reset_irq", 32'(irq_o), 0);

    // ch0 one-shot
    gate = '1;
    wr(1, 5);
    wr(0, 16'h000C);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk) tick = 1;
      @(posedge clk) #1;
      if (t == 5) begin
        chk("os_out0", 32'(out_o[0]), 1);
        chk("os_irq_early", 32'(irq_o), 0);
      end
      @(negedge clk) tick = 0;
    end
    @(posedge clk) #1;
    chk("os_irq", 32'(irq_o), 1);
    rd("os_cnt", 2, 0);
    rd("os_stat", 3, 3);
    @(negedge clk) tick = 1;
    @(negedge clk) tick = 0;
    rd("os_cnt6", 2, 0);
    wr(3, 1);
    @(posedge clk) #1;
    chk("os_irq_clr", 32'(irq_o), 0);

    // ch1 rate generator
    wr(5, 3);
    wr(4, 16'h0006);
    lows = 0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk) tick = (k % 4 == 0);
      @(posedge clk) #1;
      if (!out_o[1]) lows++;
    end
    chk("rate_lows", 32'(lows), 4);
    gate[1] = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk) tick = (k % 4 == 0);
    end
    @(negedge clk) tick = 0;
    chk("gate_out1", 32'(out_o[1]), 1);
    gate[1] = 1;

    // ch2 square wave
    wr(9, 4);
    wr(8, 16'h0007);
    @(negedge clk) tick = 1;
    period(2, 40, per);
    chk("sq_half", 32'(per), 4);
    wr(9, 0);
    period(2, 700, per);
    chk("sq_half_full", 32'(per), FULL);
    @(negedge clk) tick = 0;

    // held write strobe, then write coinciding with a tick
    wr(1, 20);
    @(negedge clk);
    bus.wb_adr_i = AW'(0);
    bus.wb_dat_i = 16'h0004;
    bus.CS_N = 0; bus.IOW_N = 0; tick = 1;
    repeat (10) @(negedge clk);
    bus.CS_N = 1; bus.IOW_N = 1; tick = 0;
    rd("hold_cnt", 2, 11);
    @(negedge clk);
    bus.wb_adr_i = AW'(1);
    bus.wb_dat_i = 16'd7;
    bus.CS_N = 0; bus.IOW_N = 0; tick = 1;
    @(negedge clk);
    bus.CS_N = 1; bus.IOW_N = 1; tick = 0;
    rd("ld_tick_cnt", 2, 7);

    // cascade
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
`ifdef S86_TIMER_CASCADE_EN
    wr(1, 10);
    wr(0, 16'h0006);
    wr(5, 3);
    wr(4, 16'h0014);
    first = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk) tick = 1;
      @(posedge clk) #1;
      if (out_o[1] && first < 0) first = n;
    end
    @(negedge clk) tick = 0;
    chk("cascade_ticks", 32'(first), 30);
`else
    wr(4, 16'h001C);
    rd("ctrl_nocas", 4, 16'h000C);
`endif

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 399) == 0);
      tick = ($urandom_range(0, 2) == 0);
      gate = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '1;
      bus.CS_N  = ($urandom_range(0, 4) == 0);
      bus.IOW_N = ($urandom_range(0, 3) != 0);
      bus.IOR_N = ($urandom_range(0, 1) != 0);
      bus.wb_adr_i = AW'($urandom);
      bus.wb_dat_i = ($urandom_range(0, 1) != 0)
                     ? 16'($urandom_range(0, 6)) : 16'($urandom);
    end
    @(negedge clk);
    rst = 0; tick = 0;
    bus.CS_N = 1; bus.IOW_N = 1; bus.IOR_N = 1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
